// File: rtl/vera_bus_pkg.sv
// Shared definitions for the VERA 16-bit-to-8-bit word bridge.
//   state_t     : sequencing states used by the bridge and its byte engine
//   VERA_DATA0/1: VERA register addresses of the two data ports
//   byte_idx_t  : selects the low (0) or high (1) byte of a CPU word
//   cnt_width() : width of a down-counter able to hold the largest timing value
package vera_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      DONE,
      RELEASE
   } state_t;

   localparam logic [4:0] VERA_DATA0 = 5'h03;
   localparam logic [4:0] VERA_DATA1 = 5'h04;

   typedef logic byte_idx_t;
   localparam byte_idx_t BYTE_LO = 1'b0;
   localparam byte_idx_t BYTE_HI = 1'b1;

   function automatic int cnt_width(input int setup_cyc, input int strobe_cyc,
                                    input int hold_cyc);
      int max_cyc;
      max_cyc = setup_cyc;
      if (strobe_cyc > max_cyc) max_cyc = strobe_cyc;
      if (hold_cyc > max_cyc) max_cyc = hold_cyc;
      return $clog2(max_cyc) + 1;
   endfunction

endpackage

// File: rtl/vera_byte_cycle.sv
// One 8-bit VERA bus access: SETUP -> STROBE -> HOLD, all outputs from flops.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin an access (accepted in IDLE or on the last HOLD cycle)
//   rw, addr, wdata     : direction (1 = read), VERA register address, write byte
//   rdata               : byte currently returned by VERA
//   sample              : high on the last STROBE cycle of a read (capture rdata now)
//   done                : high on the last HOLD cycle
//   vera_*              : VERA bus pins
//
// state   | meaning
// IDLE    | bus released, csb high
// SETUP   | csb low, address/data driven, strobes high
// STROBE  | rdb or wrb low
// HOLD    | strobes high, address/data/csb held
module vera_byte_cycle
   import vera_bus_pkg::*;
#(
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 3,
   parameter int HOLD_CYC   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rw,
   input  logic [4:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       sample,
   output logic       done,
   output logic [4:0] vera_a,
   output logic [7:0] vera_d_out,
   input  logic [7:0] vera_d_in,
   output logic       vera_d_oe,
   output logic       vera_csb,
   output logic       vera_rdb,
   output logic       vera_wrb
);

   localparam int CNT_W = cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC);

   state_t             phase;
   logic [CNT_W-1:0]   cnt;
   logic               rw_q;

   assign rdata  = vera_d_in;
   assign sample = (phase == STROBE) && (cnt == '0) && rw_q;
   assign done   = (phase == HOLD) && (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         phase      <= IDLE;
         cnt        <= '0;
         rw_q       <= 1'b0;
         vera_a     <= '0;
         vera_d_out <= '0;
         vera_d_oe  <= 1'b0;
         vera_csb   <= 1'b1;
         vera_rdb   <= 1'b1;
         vera_wrb   <= 1'b1;
      end else begin
         case (phase)
            IDLE: begin
               if (start) begin
                  phase     <= SETUP;
                  cnt       <= CNT_W'(SETUP_CYC - 1);
                  rw_q      <= rw;
                  vera_csb  <= 1'b0;
                  vera_a    <= addr;
                  vera_d_oe <= ~rw;
                  if (!rw) vera_d_out <= wdata;
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  phase <= STROBE;
                  cnt   <= CNT_W'(STROBE_CYC - 1);
                  if (rw_q) vera_rdb <= 1'b0;
                  else      vera_wrb <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            STROBE: begin
               if (cnt == '0) begin
                  phase    <= HOLD;
                  cnt      <= CNT_W'(HOLD_CYC - 1);
                  vera_rdb <= 1'b1;
                  vera_wrb <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  // Back-to-back start keeps csb low so the second byte follows
                  // without releasing the chip.
                  if (start) begin
                     phase     <= SETUP;
                     cnt       <= CNT_W'(SETUP_CYC - 1);
                     rw_q      <= rw;
                     vera_a    <= addr;
                     vera_d_oe <= ~rw;
                     if (!rw) vera_d_out <= wdata;
                  end else begin
                     phase     <= IDLE;
                     vera_csb  <= 1'b1;
                     vera_d_oe <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               phase    <= IDLE;
               vera_csb <= 1'b1;
               vera_rdb <= 1'b1;
               vera_wrb <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/vera_word_bridge.sv
// Turns one 16-bit CPU access to VERA DATA0/DATA1 into two 8-bit VERA bus
// cycles (low byte first, same port address), stalling the CPU until done.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   cpu_sel, cpu_a0, cpu_rw : decoded select, port select, direction (1 = read)
//   cpu_wdata / cpu_rdata   : write word / last completed read word
//   cpu_ready               : one-cycle completion pulse
//   busy                    : access in progress
//   vera_*                  : VERA bus pins, all registered
//
// state   | meaning
// IDLE    | waiting for cpu_sel
// SETUP   | a byte access is in flight (phases tracked by vera_byte_cycle)
// DONE    | one-cycle completion, cpu_ready high
// RELEASE | waiting for cpu_sel to drop so a held select cannot retrigger
module vera_word_bridge
   import vera_bus_pkg::*;
#(
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 3,
   parameter int HOLD_CYC   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_sel,
   input  logic        cpu_a0,
   input  logic        cpu_rw,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        cpu_ready,
   output logic        busy,
   output logic [4:0]  vera_a,
   output logic [7:0]  vera_d_out,
   input  logic [7:0]  vera_d_in,
   output logic        vera_d_oe,
   output logic        vera_csb,
   output logic        vera_rdb,
   output logic        vera_wrb
);

   state_t     state;
   byte_idx_t  idx;
   logic       a0_q;
   logic       rw_q;
   logic [7:0] wdata_hi_q;

   logic       byte_start;
   logic       byte_rw;
   logic [4:0] byte_addr;
   logic [7:0] byte_wdata;
   logic [7:0] byte_rdata;
   logic       byte_sample;
   logic       byte_done;

   // In IDLE the engine is fed straight from the CPU so the first SETUP
   // starts on the accepting edge; afterwards it uses the latched copies.
   always_comb begin
      byte_start = 1'b0;
      byte_rw    = rw_q;
      byte_addr  = a0_q ? VERA_DATA1 : VERA_DATA0;
      byte_wdata = wdata_hi_q;
      if (state == IDLE) begin
         byte_start = cpu_sel;
         byte_rw    = cpu_rw;
         byte_addr  = cpu_a0 ? VERA_DATA1 : VERA_DATA0;
         byte_wdata = cpu_wdata[7:0];
      end else if (state == SETUP) begin
         byte_start = byte_done && (idx == BYTE_LO);
      end
   end

   vera_byte_cycle #(
      .SETUP_CYC (SETUP_CYC),
      .STROBE_CYC(STROBE_CYC),
      .HOLD_CYC  (HOLD_CYC)
   ) u_byte_cycle (
      .clk       (clk),
      .rst       (rst),
      .start     (byte_start),
      .rw        (byte_rw),
      .addr      (byte_addr),
      .wdata     (byte_wdata),
      .rdata     (byte_rdata),
      .sample    (byte_sample),
      .done      (byte_done),
      .vera_a    (vera_a),
      .vera_d_out(vera_d_out),
      .vera_d_in (vera_d_in),
      .vera_d_oe (vera_d_oe),
      .vera_csb  (vera_csb),
      .vera_rdb  (vera_rdb),
      .vera_wrb  (vera_wrb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= BYTE_LO;
         a0_q       <= 1'b0;
         rw_q       <= 1'b0;
         wdata_hi_q <= '0;
         cpu_rdata  <= '0;
         cpu_ready  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         cpu_ready <= 1'b0;
         if (byte_sample) begin
            if (idx == BYTE_HI) cpu_rdata[15:8] <= byte_rdata;
            else                cpu_rdata[7:0]  <= byte_rdata;
         end
         case (state)
            IDLE: begin
               if (cpu_sel) begin
                  state      <= SETUP;
                  idx        <= BYTE_LO;
                  a0_q       <= cpu_a0;
                  rw_q       <= cpu_rw;
                  wdata_hi_q <= cpu_wdata[15:8];
                  busy       <= 1'b1;
               end
            end
            SETUP: begin
               if (byte_done) begin
                  if (idx == BYTE_LO) begin
                     idx <= BYTE_HI;
                  end else begin
                     state     <= DONE;
                     cpu_ready <= 1'b1;
                     busy      <= 1'b0;
                  end
               end
            end
            DONE: begin
               state <= cpu_sel ? RELEASE : IDLE;
            end
            RELEASE: begin
               if (!cpu_sel) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vera_word_bridge.sv
module tb_vera_word_bridge;
   import vera_bus_pkg::*;

   logic        clk;
   logic        rst0, rst1;
   logic        sel_v;
   logic        dsel;
   logic        a0_v, rw_v;
   logic [15:0] wdata_v;
   logic [7:0]  vin;

   logic        sel0, sel1;
   logic [15:0] rdata0, rdata1;
   logic        ready0, ready1, busy0, busy1;
   logic [4:0]  a0_o, a1_o;
   logic [7:0]  dout0, dout1;
   logic        doe0, doe1, csb0, csb1, rdb0, rdb1, wrb0, wrb1;

   assign sel0 = sel_v & ~dsel;
   assign sel1 = sel_v & dsel;

   vera_word_bridge u_dut0 (
      .clk(clk), .rst(rst0), .cpu_sel(sel0), .cpu_a0(a0_v), .cpu_rw(rw_v),
      .cpu_wdata(wdata_v), .cpu_rdata(rdata0), .cpu_ready(ready0), .busy(busy0),
      .vera_a(a0_o), .vera_d_out(dout0), .vera_d_in(vin), .vera_d_oe(doe0),
      .vera_csb(csb0), .vera_rdb(rdb0), .vera_wrb(wrb0)
   );

   vera_word_bridge #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3)) u_dut1 (
      .clk(clk), .rst(rst1), .cpu_sel(sel1), .cpu_a0(a0_v), .cpu_rw(rw_v),
      .cpu_wdata(wdata_v), .cpu_rdata(rdata1), .cpu_ready(ready1), .busy(busy1),
      .vera_a(a1_o), .vera_d_out(dout1), .vera_d_in(vin), .vera_d_oe(doe1),
      .vera_csb(csb1), .vera_rdb(rdb1), .vera_wrb(wrb1)
   );

   logic [15:0] m_rdata;
   logic        m_ready, m_busy, m_doe, m_csb, m_rdb, m_wrb;
   logic [4:0]  m_a;
   logic [7:0]  m_dout;
   assign m_rdata = dsel ? rdata1 : rdata0;
   assign m_ready = dsel ? ready1 : ready0;
   assign m_busy  = dsel ? busy1  : busy0;
   assign m_doe   = dsel ? doe1   : doe0;
   assign m_csb   = dsel ? csb1   : csb0;
   assign m_rdb   = dsel ? rdb1   : rdb0;
   assign m_wrb   = dsel ? wrb1   : wrb0;
   assign m_a     = dsel ? a1_o   : a0_o;
   assign m_dout  = dsel ? dout1  : dout0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int overlap_cnt = 0;
   int strobe_no_cs = 0;

   always @(negedge clk) begin
      if ((!rdb0 && !wrb0) || (!rdb1 && !wrb1)) overlap_cnt++;
      if (((!rdb0 || !wrb0) && csb0) || ((!rdb1 || !wrb1) && csb1)) strobe_no_cs++;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Per-transaction observations.
   int          lat, ready_cnt, csb_low, a_bad, doe_cnt;
   int          wr_pulses, rd_pulses, wr_cur, rd_cur;
   int          wr_len[4], rd_len[4];
   logic [7:0]  wr_byte[4];
   logic [15:0] rdata_at;

   task automatic run_txn(input bit d, input bit a0, input bit rw, input logic [15:0] wd,
                          input logic [7:0] rlo, input logic [7:0] rhi,
                          input logic [4:0] exp_a, input int sel_hold, input int n);
      lat = -1; ready_cnt = 0; csb_low = 0; a_bad = 0; doe_cnt = 0;
      wr_pulses = 0; rd_pulses = 0; wr_cur = 0; rd_cur = 0;
      for (int i = 0; i < 4; i++) begin
         wr_len[i] = 0; rd_len[i] = 0; wr_byte[i] = 8'h00;
      end
      rdata_at = 16'hxxxx;
      @(negedge clk);
      dsel = d; a0_v = a0; rw_v = rw; wdata_v = wd; vin = rlo; sel_v = 1'b1;
      @(posedge clk);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (k == sel_hold - 1) sel_v = 1'b0;
         if (!m_csb) begin
            csb_low++;
            if (m_a != exp_a) a_bad++;
            if (m_doe) doe_cnt++;
         end
         if (!m_wrb) begin
            if (wr_cur == 0 && wr_pulses < 4) wr_byte[wr_pulses] = m_dout;
            wr_cur++;
         end else if (wr_cur != 0) begin
            if (wr_pulses < 4) wr_len[wr_pulses] = wr_cur;
            wr_pulses++;
            wr_cur = 0;
         end
         if (!m_rdb) begin
            rd_cur++;
         end else if (rd_cur != 0) begin
            if (rd_pulses < 4) rd_len[rd_pulses] = rd_cur;
            rd_pulses++;
            rd_cur = 0;
            vin = rhi;
         end
         if (m_ready) begin
            ready_cnt++;
            if (ready_cnt == 1) begin
               lat = k;
               rdata_at = m_rdata;
            end
         end
      end
      sel_v = 1'b0;
   endtask

   typedef struct {
      bit          a0;
      bit          rw;
      logic [15:0] wdata;
      logic [7:0]  rlo;
      logic [7:0]  rhi;
      logic [4:0]  exp_a;
      logic [7:0]  exp_b0;
      logic [7:0]  exp_b1;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs[4];

   initial begin
      vecs[0] = '{a0:1'b0, rw:1'b0, wdata:16'hBEEF, rlo:8'h00, rhi:8'h00, exp_a:5'h03,
                  exp_b0:8'hEF, exp_b1:8'hBE, exp_rdata:16'h0000};
      vecs[1] = '{a0:1'b1, rw:1'b1, wdata:16'h0000, rlo:8'h34, rhi:8'h12, exp_a:5'h04,
                  exp_b0:8'h00, exp_b1:8'h00, exp_rdata:16'h1234};
      vecs[2] = '{a0:1'b0, rw:1'b1, wdata:16'hFFFF, rlo:8'hA5, rhi:8'h5A, exp_a:5'h03,
                  exp_b0:8'h00, exp_b1:8'h00, exp_rdata:16'h5AA5};
      vecs[3] = '{a0:1'b1, rw:1'b0, wdata:16'h00FF, rlo:8'h00, rhi:8'h00, exp_a:5'h04,
                  exp_b0:8'hFF, exp_b1:8'h00, exp_rdata:16'h5AA5};

      rst0 = 1'b1; rst1 = 1'b1; sel_v = 1'b0; dsel = 1'b0;
      a0_v = 1'b0; rw_v = 1'b0; wdata_v = 16'h0; vin = 8'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_csb", int'(csb0), 1);
      chk("rst_rdb", int'(rdb0), 1);
      chk("rst_wrb", int'(wrb0), 1);
      chk("rst_doe", int'(doe0), 0);
      chk("rst_a", int'(a0_o), 0);
      chk("rst_dout", int'(dout0), 0);
      chk("rst_ready", int'(ready0), 0);
      chk("rst_rdata", int'(rdata0), 0);
      chk("rst_busy", int'(busy0), 0);
      chk("rst_csb1", int'(csb1), 1);
      rst0 = 1'b0; rst1 = 1'b0;
      repeat (2) @(negedge clk);

      // Table-driven word transfers on the default-timing bridge.
      for (int v = 0; v < 4; v++) begin
         run_txn(1'b0, vecs[v].a0, vecs[v].rw, vecs[v].wdata, vecs[v].rlo, vecs[v].rhi,
                 vecs[v].exp_a, 1, 14);
         chk($sformatf("v%0d_latency", v), lat, 10);
         chk($sformatf("v%0d_ready_cnt", v), ready_cnt, 1);
         chk($sformatf("v%0d_csb_low", v), csb_low, 10);
         chk($sformatf("v%0d_addr_bad", v), a_bad, 0);
         chk($sformatf("v%0d_rdata", v), int'(rdata_at), int'(vecs[v].exp_rdata));
         if (vecs[v].rw) begin
            chk($sformatf("v%0d_rd_pulses", v), rd_pulses, 2);
            chk($sformatf("v%0d_rd_len0", v), rd_len[0], 3);
            chk($sformatf("v%0d_rd_len1", v), rd_len[1], 3);
            chk($sformatf("v%0d_doe_cycles", v), doe_cnt, 0);
            chk($sformatf("v%0d_wr_pulses", v), wr_pulses, 0);
         end else begin
            chk($sformatf("v%0d_wr_pulses", v), wr_pulses, 2);
            chk($sformatf("v%0d_wr_len0", v), wr_len[0], 3);
            chk($sformatf("v%0d_wr_len1", v), wr_len[1], 3);
            chk($sformatf("v%0d_wr_byte0", v), int'(wr_byte[0]), int'(vecs[v].exp_b0));
            chk($sformatf("v%0d_wr_byte1", v), int'(wr_byte[1]), int'(vecs[v].exp_b1));
            chk($sformatf("v%0d_doe_cycles", v), doe_cnt, 10);
            chk($sformatf("v%0d_rd_pulses", v), rd_pulses, 0);
         end
      end

      // Held select: one transaction only, then a fresh select starts another.
      run_txn(1'b0, 1'b0, 1'b0, 16'h1357, 8'h00, 8'h00, 5'h03, 30, 40);
      chk("held_ready_cnt", ready_cnt, 1);
      chk("held_csb_low", csb_low, 10);
      chk("held_wr_pulses", wr_pulses, 2);
      run_txn(1'b0, 1'b0, 1'b0, 16'h2468, 8'h00, 8'h00, 5'h03, 1, 14);
      chk("reselect_ready_cnt", ready_cnt, 1);
      chk("reselect_latency", lat, 10);
      chk("reselect_byte1", int'(wr_byte[1]), 8'h24);

      // Early select drop: access still runs to completion.
      run_txn(1'b0, 1'b1, 1'b0, 16'hA1B2, 8'h00, 8'h00, 5'h04, 2, 16);
      chk("early_ready_cnt", ready_cnt, 1);
      chk("early_latency", lat, 10);
      chk("early_wr_pulses", wr_pulses, 2);
      chk("early_byte0", int'(wr_byte[0]), 8'hB2);
      chk("early_state_idle", int'(u_dut0.state), int'(IDLE));
      chk("early_busy", int'(busy0), 0);

      // Reset while the write strobe is low.
      @(negedge clk);
      dsel = 1'b0; a0_v = 1'b0; rw_v = 1'b0; wdata_v = 16'h4242; sel_v = 1'b1;
      begin
         int guard;
         guard = 0;
         while (wrb0 && guard < 20) begin
            @(negedge clk);
            guard++;
         end
      end
      chk("rst_mid_wrb_low", int'(wrb0), 0);
      rst0 = 1'b1; sel_v = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_wrb", int'(wrb0), 1);
      chk("rst_mid_csb", int'(csb0), 1);
      chk("rst_mid_busy", int'(busy0), 0);
      chk("rst_mid_rdata", int'(rdata0), 0);
      @(negedge clk);
      rst0 = 1'b0;
      repeat (2) @(negedge clk);

      // Alternate timing: SETUP=2 STROBE=1 HOLD=3.
      run_txn(1'b1, 1'b0, 1'b0, 16'hC3A5, 8'h00, 8'h00, 5'h03, 1, 16);
      chk("sweep_wr_latency", lat, 12);
      chk("sweep_wr_ready_cnt", ready_cnt, 1);
      chk("sweep_wr_csb_low", csb_low, 12);
      chk("sweep_wr_len0", wr_len[0], 1);
      chk("sweep_wr_len1", wr_len[1], 1);
      chk("sweep_wr_byte0", int'(wr_byte[0]), 8'hA5);
      chk("sweep_wr_byte1", int'(wr_byte[1]), 8'hC3);
      run_txn(1'b1, 1'b1, 1'b1, 16'h0000, 8'h77, 8'h88, 5'h04, 1, 16);
      chk("sweep_rd_latency", lat, 12);
      chk("sweep_rd_len0", rd_len[0], 1);
      chk("sweep_rd_rdata", int'(rdata_at), 16'h8877);
      chk("sweep_rd_addr_bad", a_bad, 0);

      chk("strobe_overlap", overlap_cnt, 0);
      chk("strobe_without_cs", strobe_no_cs, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
